// File: rtl/issue_queue.sv
// Circular instruction buffer between fetch and the dual-issue dependency checker.
// Takes up to two instructions per cycle, presents the two oldest, retires 0/1/2 per cycle.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PCW   = 13,
    parameter int IW    = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       stall,
    input  logic [1:0]                 in_valid,
    input  logic [PCW-1:0]             in_pc0,
    input  logic [PCW-1:0]             in_pc1,
    input  logic [IW-1:0]              in_inst0,
    input  logic [IW-1:0]              in_inst1,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [PCW-1:0]             out_pc0,
    output logic [PCW-1:0]             out_pc1,
    output logic [IW-1:0]              out_inst0,
    output logic [IW-1:0]              out_inst1,
    input  logic [1:0]                 issue_cnt,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PCW-1:0] pc_mem   [DEPTH];
    logic [IW-1:0]  inst_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [1:0]    avail;
    logic [1:0]    deq;
    logic [1:0]    enq_n;
    logic          proto_err;

    // Handshake: fetch slots are taken on a clock edge only when in_ready is high
    // (two free entries) and in_valid is 01 or 11; otherwise fetch must hold them.
    // The checker reports consumption via issue_cnt in the same cycle it sees out_valid.
    assign in_ready = (DEPTH_C - count) >= CW'(2);

    always_comb begin
        avail = (count >= CW'(2)) ? 2'd2 : count[1:0];
        deq   = 2'd0;
        if (!stall) begin
            deq = (issue_cnt < avail) ? issue_cnt : avail;
        end
        enq_n = 2'd0;
        if (in_ready && !flush) begin
            case (in_valid)
                2'b01:   enq_n = 2'd1;
                2'b11:   enq_n = 2'd2;
                default: enq_n = 2'd0;
            endcase
        end
        proto_err = (in_valid == 2'b10) || (issue_cnt == 2'b11) ||
                    (!stall && (issue_cnt > avail));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq);
            tail  <= tail + AW'(enq_n);
            count <= count + CW'(enq_n) - CW'(deq);
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

    // Entry storage carries no reset; stale contents are masked by count.
    always_ff @(posedge CLK) begin
        if (!RST && enq_n != 2'd0) begin
            pc_mem[tail]   <= in_pc0;
            inst_mem[tail] <= in_inst0;
            if (enq_n == 2'd2) begin
                pc_mem[tail + AW'(1)]   <= in_pc1;
                inst_mem[tail + AW'(1)] <= in_inst1;
            end
        end
    end

    assign head_p1      = head + AW'(1);
    assign out_valid[0] = (count >= CW'(1));
    assign out_valid[1] = (count >= CW'(2));
    assign out_pc0      = out_valid[0] ? pc_mem[head]      : '0;
    assign out_inst0    = out_valid[0] ? inst_mem[head]    : '0;
    assign out_pc1      = out_valid[1] ? pc_mem[head_p1]   : '0;
    assign out_inst1    = out_valid[1] ? inst_mem[head_p1] : '0;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed vector table, then random traffic against a
// queue-based reference model of the buffer.
module tb_issue_queue;
    localparam int DEPTH = 8;
    localparam int PCW   = 13;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic            flush;
    logic            stall;
    logic [1:0]      in_valid;
    logic [PCW-1:0]  in_pc0, in_pc1;
    logic [IW-1:0]   in_inst0, in_inst1;
    logic            in_ready;
    logic [1:0]      out_valid;
    logic [PCW-1:0]  out_pc0, out_pc1;
    logic [IW-1:0]   out_inst0, out_inst1;
    logic [1:0]      issue_cnt;
    logic [CW-1:0]   count;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    issue_queue #(.DEPTH(DEPTH), .PCW(PCW), .IW(IW)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .issue_cnt(issue_cnt), .count(count), .err(err)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    // reference model: an ordered list of entries plus a sticky error bit
    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [IW-1:0]  inst;
    } ent_t;
    ent_t m_q[$];
    bit   m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int sz;
        int avail;
        int d;
        if (RST) begin
            m_q.delete();
            m_err = 0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            sz    = m_q.size();
            avail = (sz < 2) ? sz : 2;
            if (in_valid == 2'b10) m_err = 1;
            if (issue_cnt == 2'd3) m_err = 1;
            if (!stall && int'(issue_cnt) > avail) m_err = 1;
            d = stall ? 0 : ((int'(issue_cnt) < avail) ? int'(issue_cnt) : avail);
            for (int k = 0; k < d; k++) void'(m_q.pop_front());
            if (DEPTH - sz >= 2) begin
                if (in_valid == 2'b01 || in_valid == 2'b11) m_q.push_back({in_pc0, in_inst0});
                if (in_valid == 2'b11) m_q.push_back({in_pc1, in_inst1});
            end
        end
    endtask

    task automatic model_check();
        int sz;
        logic [PCW-1:0] e_pc0, e_pc1;
        logic [IW-1:0]  e_i0, e_i1;
        sz    = m_q.size();
        e_pc0 = (sz >= 1) ? m_q[0].pc   : '0;
        e_i0  = (sz >= 1) ? m_q[0].inst : '0;
        e_pc1 = (sz >= 2) ? m_q[1].pc   : '0;
        e_i1  = (sz >= 2) ? m_q[1].inst : '0;
        chk("m_count",     32'(count),     32'(sz));
        chk("m_in_ready",  32'(in_ready),  32'((DEPTH - sz) >= 2));
        chk("m_out_valid", 32'(out_valid), 32'({sz >= 2, sz >= 1}));
        chk("m_out_pc0",   32'(out_pc0),   32'(e_pc0));
        chk("m_out_pc1",   32'(out_pc1),   32'(e_pc1));
        chk("m_out_inst0", out_inst0,      e_i0);
        chk("m_out_inst1", out_inst1,      e_i1);
        chk("m_err",       32'(err),       32'(m_err));
    endtask

    // driver: apply one cycle of inputs, advance the model at the edge, check after it
    task automatic step(input logic r, input logic f, input logic s,
                        input logic [1:0] iv, input logic [1:0] ic,
                        input logic [PCW-1:0] p0, input logic [PCW-1:0] p1,
                        input logic [IW-1:0] i0, input logic [IW-1:0] i1);
        RST = r; flush = f; stall = s; in_valid = iv; issue_cnt = ic;
        in_pc0 = p0; in_pc1 = p1; in_inst0 = i0; in_inst1 = i1;
        @(posedge CLK);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic rst, flush, stall;
        logic [1:0] iv, ic;
        logic [PCW-1:0] pc0;
        logic [IW-1:0] i0, i1;
        int e_cnt;
        logic [1:0] e_ov;
        logic e_rdy, e_err;
        logic [PCW-1:0] e_pc0;
        logic [IW-1:0] e_i0, e_i1;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic f, input logic s,
                               input logic [1:0] iv, input logic [1:0] ic, input int pc,
                               input int e_cnt, input logic [1:0] e_ov, input logic e_rdy,
                               input logic e_err, input int e_pc);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.iv = iv; t.ic = ic;
        t.pc0 = PCW'(pc);
        t.i0  = 32'h1000_0000 | 32'(pc);
        t.i1  = 32'h1000_0000 | 32'(pc + 4);
        t.e_cnt = e_cnt; t.e_ov = e_ov; t.e_rdy = e_rdy; t.e_err = e_err;
        t.e_pc0 = PCW'(e_pc);
        t.e_i0  = e_ov[0] ? (32'h1000_0000 | 32'(e_pc)) : 32'd0;
        t.e_i1  = e_ov[1] ? (32'h1000_0000 | 32'(e_pc + 4)) : 32'd0;
        return t;
    endfunction

    initial begin
        vec_t t;
        RST = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 2'b00; issue_cnt = 2'd0;
        in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
        m_err = 0;

        //             rst f s iv ic pc      cnt ov rdy err pc0
        tbl.push_back(v(1, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0));
        t = v(0, 0, 0, 3, 0, 0, 2, 3, 1, 0, 0);
        t.i0 = 32'h0010_0093; t.i1 = 32'h0020_0113;
        t.e_i0 = 32'h0010_0093; t.e_i1 = 32'h0020_0113;
        tbl.push_back(t);
        t = v(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 4);
        t.e_i0 = 32'h0020_0113; t.e_i1 = 32'd0;
        tbl.push_back(t);
        tbl.push_back(v(1, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h00,   2, 3, 1, 0, 'h00));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h08,   4, 3, 1, 0, 'h00));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h10,   6, 3, 1, 0, 'h00));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h18,   8, 3, 0, 0, 'h00));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h20,   8, 3, 0, 0, 'h00));
        tbl.push_back(v(0, 0, 0, 0, 2, 0,      6, 3, 1, 0, 'h08));
        tbl.push_back(v(0, 0, 0, 0, 2, 0,      4, 3, 1, 0, 'h10));
        tbl.push_back(v(0, 0, 0, 0, 2, 0,      2, 3, 1, 0, 'h18));
        tbl.push_back(v(0, 0, 0, 0, 2, 0,      0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h40,   2, 3, 1, 0, 'h40));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h48,   4, 3, 1, 0, 'h40));
        tbl.push_back(v(0, 0, 0, 3, 0, 'h50,   6, 3, 1, 0, 'h40));
        tbl.push_back(v(0, 0, 0, 3, 2, 'h58,   6, 3, 1, 0, 'h48));
        tbl.push_back(v(0, 0, 1, 0, 2, 0,      6, 3, 1, 0, 'h48));
        tbl.push_back(v(0, 0, 1, 0, 2, 0,      6, 3, 1, 0, 'h48));
        tbl.push_back(v(0, 0, 1, 0, 2, 0,      6, 3, 1, 0, 'h48));
        tbl.push_back(v(0, 1, 0, 3, 0, 'h60,   0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 'h60,   1, 1, 1, 0, 'h60));
        tbl.push_back(v(0, 0, 0, 0, 2, 0,      0, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0,      0, 0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 'h70,   0, 0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            step(t.rst, t.flush, t.stall, t.iv, t.ic, t.pc0, t.pc0 + PCW'(4), t.i0, t.i1);
            chk($sformatf("row%0d_count", i),     32'(count),     32'(t.e_cnt));
            chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(t.e_ov));
            chk($sformatf("row%0d_in_ready", i),  32'(in_ready),  32'(t.e_rdy));
            chk($sformatf("row%0d_err", i),       32'(err),       32'(t.e_err));
            chk($sformatf("row%0d_out_pc0", i),   32'(out_pc0),   32'(t.e_pc0));
            chk($sformatf("row%0d_out_inst0", i), out_inst0,      t.e_i0);
            chk($sformatf("row%0d_out_inst1", i), out_inst1,      t.e_i1);
        end

        // random traffic, mostly legal, with occasional protocol errors, flushes and resets
        for (int n = 0; n < 3000; n++) begin
            logic r, f, s;
            logic [1:0] iv, ic;
            int sel;
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 39) == 0);
            s   = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 99);
            iv  = (sel < 30) ? 2'b00 : (sel < 60) ? 2'b01 : (sel < 98) ? 2'b11 : 2'b10;
            ic  = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 95 && int'(ic) > m_q.size()) ic = 2'(m_q.size());
            if ($urandom_range(0, 199) == 0) ic = 2'd3;
            step(r, f, s, iv, ic, PCW'($urandom), PCW'($urandom), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
